// File: rtl/barrel_pkg.sv
// barrel_pkg: definitions shared by the barrel core fetch front end.
//   XLEN / ILEN        : data-path and instruction widths
//   RESET_PC_DEFAULT   : fetch PC used after reset unless overridden
//   fetch_entry_t      : one buffered fetch, {pc, instr}, 64 bits packed
package barrel_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetch entries.
//   clk, resetn : clock, asynchronous active-low reset (clears all storage)
//   push, din   : write din at the write pointer
//   pop         : retire the entry at the read pointer
//   flush       : empty the buffer and rewind both pointers; wins over push/pop
//   dout        : entry at the read pointer (registered storage, no bypass)
//   count       : number of valid entries, 0..DEPTH
// The owner guarantees push never overflows and pop never underflows.
module fetch_fifo
  import barrel_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        // DEPTH is a power of two, so natural overflow wraps the pointer.
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end between rom32 and decode.
//   clk, resetn        : clock, asynchronous active-low reset
//   rom_addr, rom_ren  : word address / read enable to rom32 (ren = issue)
//   rom_dout           : rom32 data, valid the cycle after rom_ren
//   redirect, redirect_pc : flush everything and restart at redirect_pc & ~3
//   halt               : stop issuing; outstanding read still lands
//   out_valid, out_ready, out_instr, out_pc : head of queue to decode
//
// Handshake: a head transfers on a rising edge where out_valid && out_ready
// and redirect is low. out_valid, out_instr and out_pc depend only on
// registered state; out_valid never drops without a transfer, redirect or
// reset. A head offered in a redirect cycle is discarded, not consumed.
module fetch_queue
  import barrel_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DEPTH      = 2,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic [ADDR_WIDTH-3:0] rom_addr,
  output logic                  rom_ren,
  input  logic [31:0]           rom_dout,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  input  logic                  halt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [31:0]           out_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;
  logic          push, pop, issue;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  fetch_entry_t  fifo_din, fifo_dout;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready & ~redirect;
  assign push      = inflight_q & ~redirect;

  // Slots already spoken for after this cycle's pop: buffered entries plus
  // the read whose data is arriving now. Issuing only while this is below
  // DEPTH means every returning word has a slot waiting for it.
  assign credit_used = {1'b0, count} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
  assign issue       = resetn & ~redirect & ~halt & (credit_used < DEPTH_C);

  assign rom_ren  = issue;
  assign rom_addr = fetch_pc_q[ADDR_WIDTH-1:2];

  assign fifo_din.pc    = inflight_pc_q;
  assign fifo_din.instr = rom_dout;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~32'h3;
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .flush  (redirect),
    .din    (fifo_din),
    .dout   (fifo_dout),
    .count  (count)
  );

  assign out_instr = fifo_dout.instr;
  assign out_pc    = fifo_dout.pc;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [9:0]  rom_addr;
  logic        rom_ren;
  logic [31:0] rom_dout = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  fetch_queue #(
    .ADDR_WIDTH (12),
    .DEPTH      (2),
    .RESET_PC   (32'h0)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rom_addr    (rom_addr),
    .rom_ren     (rom_ren),
    .rom_dout    (rom_dout),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  // rom32 model: word i holds 0x1000 + i, one-cycle read latency.
  always @(posedge clk) begin
    if (rom_ren) rom_dout <= 32'h1000 + {22'd0, rom_addr};
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  // Monitor: a transfer happens on the coming edge when valid & ready & !redirect.
  always begin
    logic [63:0] e;
    @(negedge clk);
    #1;
    if (resetn && out_valid && out_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_head: got pc %h instr %h, required no transfer", out_pc, out_instr);
      end else begin
        e = exp_q.pop_front();
        check("head_entry", {out_pc, out_instr}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Hold out_ready high until n heads have been offered; count bubbles
  // that appear after the first head.
  task automatic consume(input int n, input string name);
    int k = 0;
    int gaps = 0;
    int guard = 0;
    bit started = 1'b0;
    while (k < n && guard < 40) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (out_valid) begin
        k++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      guard++;
    end
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_heads"}, 64'(k), 64'(n));
    check({name, "_bubbles"}, 64'(gaps), 64'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_rom_ren", 64'(rom_ren), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);

    // 1: release reset, stream from 0
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    resetn    = 1'b1;
    #1;
    check("t1_rom_ren", 64'(rom_ren), 64'd1);
    check("t1_rom_addr", 64'(rom_addr), 64'd0);
    expect_entry(32'h0, 32'h1000);
    expect_entry(32'h4, 32'h1001);
    expect_entry(32'h8, 32'h1002);
    expect_entry(32'hC, 32'h1003);
    consume(4, "t1");

    // 2: backpressure for 6 cycles, queue fills, fetch stops
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t2_stall_rom_ren", 64'(rom_ren), 64'd0);
      check("t2_stall_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    expect_entry(32'h10, 32'h1004);
    expect_entry(32'h14, 32'h1005);
    expect_entry(32'h18, 32'h1006);
    expect_entry(32'h1C, 32'h1007);
    consume(4, "t2");

    // 3: redirect to 0x103 while one entry buffered and one read in flight
    repeat (2) @(negedge clk);
    expect_entry(32'h20, 32'h1008);
    expect_entry(32'h24, 32'h1009);
    consume(2, "t3_pre");
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    #1;
    check("t3_redirect_ren", 64'(rom_ren), 64'd0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("t3_t1_valid", 64'(out_valid), 64'd0);
    check("t3_t1_ren", 64'(rom_ren), 64'd1);
    check("t3_t1_addr", 64'(rom_addr), 64'h40);
    expect_entry(32'h100, 32'h1040);
    expect_entry(32'h104, 32'h1041);
    expect_entry(32'h108, 32'h1042);
    consume(3, "t3");

    // 4: redirect to the top of the address space, wrap to 0
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect  = 1'b0;
    out_ready = 1'b1;
    expect_entry(32'hFFFF_FFFC, 32'h13FF);
    expect_entry(32'h0, 32'h1000);
    expect_entry(32'h4, 32'h1001);
    #1;
    check("t4_addr_0", 64'(rom_addr), 64'h3FF);
    check("t4_ren_0", 64'(rom_ren), 64'd1);
    @(negedge clk);
    #1;
    check("t4_addr_1", 64'(rom_addr), 64'h000);
    check("t4_valid_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    check("t4_addr_2", 64'(rom_addr), 64'h001);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);

    // 5: halt for 4 cycles with out_ready held high
    halt = 1'b1;
    expect_entry(32'h8, 32'h1002);
    expect_entry(32'hC, 32'h1003);
    expect_entry(32'h10, 32'h1004);
    expect_entry(32'h14, 32'h1005);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t5_halt_ren", 64'(rom_ren), 64'd0);
      if (i >= 2) check("t5_halt_drained", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    halt = 1'b0;
    #1;
    check("t5_resume_ren", 64'(rom_ren), 64'd1);
    check("t5_resume_addr", 64'(rom_addr), 64'h4);
    repeat (4) @(negedge clk);
    out_ready = 1'b0;

    // 6: asynchronous reset pulse between edges, with a read in flight
    #3;
    resetn = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_instr", 64'(out_instr), 64'd0);
    check("t6_rst_pc", 64'(out_pc), 64'd0);
    check("t6_rst_ren", 64'(rom_ren), 64'd0);
    @(negedge clk);
    #3;
    resetn = 1'b1;
    #1;
    check("t6_rel_ren", 64'(rom_ren), 64'd1);
    check("t6_rel_addr", 64'(rom_addr), 64'd0);
    check("t6_rel_valid", 64'(out_valid), 64'd0);
    expect_entry(32'h0, 32'h1000);
    expect_entry(32'h4, 32'h1001);
    expect_entry(32'h8, 32'h1002);
    consume(3, "t6");

    // final report
    repeat (3) @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #20000;
    n_fail++;
    $display("FAIL timeout: simulation still running at %0t, required completion", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction-fetch front end for the barrel core. It sits between the rom32 instruction ROM and the core's decode stage.
- Issues sequential word reads to rom32, which has one-cycle synchronous read latency.
- Buffers returned words with their PCs in a small queue.
- Presents them to decode over a valid/ready handshake.
- Accepts a redirect, for jumps and taken branches, that flushes all buffered and in-flight fetches and restarts at a new PC.

Parameters:
ADDR_WIDTH, 12, ROM byte-address width; rom_addr is [ADDR_WIDTH-1:2]
DEPTH, 2, queue entries (power of two, >=2)
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk  in  1  clock
resetn  in  1  asynchronous, active-low reset
rom_addr  out  ADDR_WIDTH-2  word address to rom32 (fetch_pc[ADDR_WIDTH-1:2])
rom_ren  out  1  rom32 read enable (combinational = issue)
rom_dout  in  32  rom32 data, valid the cycle after rom_ren
redirect  in  1  flush and restart fetch
redirect_pc  in  32  restart PC; bits [1:0] ignored (treated as 0)
halt  in  1  stop issuing new fetches
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  32  head instruction
out_pc  out  32  head PC

Behaviour:
- Reset is asynchronous and active-low. While resetn=0:
  - fetch_pc=RESET_PC, count=0, inflight=0.
  - All queue storage is 0, so out_valid=0, out_instr=0, out_pc=0.
  - rom_ren=0.
- State:
  - fetch_pc[31:0]: next address to issue.
  - inflight (1 bit) and inflight_pc: a read issued last cycle whose data is on rom_dout this cycle.
  - Circular queue: rd_ptr, wr_ptr, count 0..DEPTH.
- pop = out_valid & out_ready & !redirect.
- push = inflight & !redirect. On push, {rom_dout, inflight_pc} is written at wr_ptr.
- issue = resetn & !redirect & !halt & (count + inflight - pop < DEPTH).
  - Occupancy plus outstanding reads never exceeds DEPTH, so no ROM data is ever dropped.
- On issue:
  - rom_ren=1 and rom_addr=fetch_pc[ADDR_WIDTH-1:2].
  - inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4. The +4 wraps modulo 2^32; rom_addr aliases modulo ROM size.
- No issue: inflight<=0 and fetch_pc holds.
- rom_addr when idle: holds the fetch_pc-derived value. The ROM ignores it because rom_ren=0.
- Queue update: count <= count + push - pop. Pointers advance mod DEPTH. Simultaneous push and pop at count=DEPTH-1 or count=1 is legal, and count is unchanged.
- Outputs: out_valid = (count != 0); out_instr and out_pc come from the entry at rd_ptr. All three are registered-state derived, with no combinational path from rom_dout.
- Redirect has top priority in the cycle it is asserted:
  - count<=0 and rd_ptr=wr_ptr<=0.
  - inflight<=0, so data returning this cycle is discarded.
  - fetch_pc<=redirect_pc & ~3.
  - No issue and no pop. A head offered in that cycle is void and is not considered consumed.
- Latencies:
  - Redirect at cycle T: issue at T+1, out_valid at T+2 with out_pc=redirect_pc.
  - Reset release: first issue in the first cycle with resetn=1, out_valid one cycle later.
- Steady state with out_ready=1 and DEPTH>=2: one instruction per cycle.
- Halt:
  - Issue stops; an in-flight read still completes and is pushed; the queue drains normally.
  - Deasserting halt resumes fetching at the unchanged fetch_pc.
  - Redirect during halt is honoured.
- Reset mid-operation: all state is cleared immediately. The outstanding ROM read is ignored because inflight=0.

Decomposition:
- Shared package barrel_pkg:
  - XLEN=32 and instruction width.
  - RESET_PC default.
  - The fetch entry record {pc, instr} as a 64-bit packed typedef fetch_entry_t.
- One sub-module: fetch_fifo.
  - Synchronous circular buffer with parameter DEPTH and a flush input that has priority over push and pop.
  - Asynchronous active-low reset.
  - Ports: push/pop/flush, din/dout (fetch_entry_t), count.
- fetch_queue holds the issue/credit logic, fetch_pc and the inflight tracking.

Test Plan:
1. Release reset with RESET_PC=0, ROM word i = 0x1000+i, and out_ready=1 → rom_ren=1 with rom_addr=0 in cycle 0. out_valid=1 with out_pc=0 and out_instr=0x1000 in cycle 1. PCs 4, 8, 12 follow on consecutive cycles with no bubbles.
2. Stream, then hold out_ready=0 for 6 cycles → count reaches DEPTH=2 and rom_ren stays 0 thereafter. On release, outputs are the next two PCs in order with no loss or duplication, then fetching resumes.
3. Redirect=1 with redirect_pc=0x103 while inflight=1 and count=1 → the following cycles show no out_valid from old entries. rom_addr=0x40 (0x100>>2) at T+1. out_pc=0x100 at T+2.
4. Redirect to 0xFFFFFFFC → out_pc sequence 0xFFFFFFFC, 0x00000000, 0x00000004. rom_addr sequence 0x3FF, 0x000, 0x001 for ADDR_WIDTH=12.
5. Assert halt for 4 cycles with out_ready=1 → the in-flight word is delivered, then out_valid=0 and rom_ren=0. After halt drops, fetching continues at the next sequential PC.
6. Pull resetn low mid-stream for one cycle, asynchronously between edges → out_valid=0, out_instr=0 and rom_ren=0 immediately. After release, fetching restarts at RESET_PC.
